// File: rtl/fpu_rf_pkg.sv
// Shared types for the FP register file: fcsr field layouts and the NaN-box constant.
package fpu_rf_pkg;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4,
    DYN = 3'd7
  } frm_t;

  localparam logic [31:0] NANBOX_HI = 32'hFFFF_FFFF;

endpackage

// File: rtl/f_rf_scoreboard.sv
// Busy scoreboard: one bit per FP register, set on issue, cleared on writeback.
module f_rf_scoreboard
  import fpu_rf_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 3,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       iss_valid,
  input  logic [AW-1:0]              iss_rd,
  input  logic                       clr0_valid,
  input  logic [AW-1:0]              clr0_addr,
  input  logic                       clr1_valid,
  input  logic [AW-1:0]              clr1_addr,
  input  logic [NUM_RD-1:0][AW-1:0]  rd_addr,
  output logic [NUM_RD-1:0]          rd_busy
);

  localparam bit BYP = (BYPASS != 0);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid)  set_mask[iss_rd]    = 1'b1;
    if (clr0_valid) clr_mask[clr0_addr] = 1'b1;
    if (clr1_valid) clr_mask[clr1_addr] = 1'b1;
  end

  // Set after clear: an issue landing with a completion to the same register
  // belongs to the new owner.
  always_ff @(posedge CLK) begin
    if (RST) busy_q <= '0;
    else     busy_q <= (busy_q & ~clr_mask) | set_mask;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic wr_hit;
    logic iss_hit;
    assign wr_hit  = (clr0_valid && clr0_addr == rd_addr[i]) ||
                     (clr1_valid && clr1_addr == rd_addr[i]);
    assign iss_hit = iss_valid && iss_rd == rd_addr[i];
    assign rd_busy[i] = (BYP && wr_hit) ? iss_hit : busy_q[rd_addr[i]];
  end

endmodule

// File: rtl/f_register_file_mp.sv
// Multi-port FP register file with busy scoreboard, dual write ports and fcsr (frm/fflags).
module f_register_file_mp
  import fpu_rf_pkg::*;
#(
  parameter int FLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 3,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_RD-1:0][AW-1:0]   rd_addr_i,
  output logic [NUM_RD-1:0][FLEN-1:0] rd_data_o,
  output logic [NUM_RD-1:0]           rd_busy_o,
  input  logic                        iss_valid_i,
  input  logic [AW-1:0]               iss_rd_i,
  input  logic                        fpu_wen_i,
  input  logic [AW-1:0]               fpu_waddr_i,
  input  logic [FLEN-1:0]             fpu_wdata_i,
  input  logic                        fpu_sp_i,
  input  logic [4:0]                  fpu_flags_i,
  input  logic                        ld_wen_i,
  input  logic [AW-1:0]               ld_waddr_i,
  input  logic [FLEN-1:0]             ld_wdata_i,
  input  logic                        ld_sp_i,
  input  logic                        csr_frm_wen_i,
  input  logic [2:0]                  csr_frm_i,
  input  logic                        csr_fflags_wen_i,
  input  logic [4:0]                  csr_fflags_i,
  output logic [2:0]                  frm_o,
  output logic [4:0]                  fflags_o,
  output logic                        wr_collide_o
);

  localparam bit BYP = (BYPASS != 0);

  logic [FLEN-1:0] regs [NUM_REGS];
  logic [FLEN-1:0] fpu_box;
  logic [FLEN-1:0] ld_box;
  logic            collide;
  logic            ld_win;
  logic            collide_q;
  frm_t            frm_q;
  fflags_t         fflags_q;
  logic [4:0]      fpu_fl;

  if (FLEN == 64) begin : g_box
    assign fpu_box = fpu_sp_i ? {NANBOX_HI, fpu_wdata_i[31:0]} : fpu_wdata_i;
    assign ld_box  = ld_sp_i  ? {NANBOX_HI, ld_wdata_i[31:0]}  : ld_wdata_i;
  end else begin : g_nobox
    logic unused_sp;
    assign unused_sp = fpu_sp_i ^ ld_sp_i;
    assign fpu_box   = fpu_wdata_i;
    assign ld_box    = ld_wdata_i;
  end

  // FPU port owns a contested address; the load is silently dropped.
  assign collide = fpu_wen_i && ld_wen_i && (fpu_waddr_i == ld_waddr_i);
  assign ld_win  = ld_wen_i && !collide;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      if (ld_win)    regs[ld_waddr_i]  <= ld_box;
      if (fpu_wen_i) regs[fpu_waddr_i] <= fpu_box;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic fpu_hit;
    logic ld_hit;
    assign fpu_hit = BYP && fpu_wen_i && (fpu_waddr_i == rd_addr_i[i]);
    assign ld_hit  = BYP && ld_win    && (ld_waddr_i  == rd_addr_i[i]);
    assign rd_data_o[i] = fpu_hit ? fpu_box :
                          ld_hit  ? ld_box  : regs[rd_addr_i[i]];
  end

  f_rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RD   (NUM_RD),
    .BYPASS   (BYPASS),
    .AW       (AW)
  ) u_sb (
    .CLK        (CLK),
    .RST        (RST),
    .iss_valid  (iss_valid_i),
    .iss_rd     (iss_rd_i),
    .clr0_valid (fpu_wen_i),
    .clr0_addr  (fpu_waddr_i),
    .clr1_valid (ld_wen_i),
    .clr1_addr  (ld_waddr_i),
    .rd_addr    (rd_addr_i),
    .rd_busy    (rd_busy_o)
  );

  assign fpu_fl = fpu_wen_i ? fpu_flags_i : 5'b0;

  // A CSR write replaces fflags but must not lose a same-cycle retirement.
  always_ff @(posedge CLK) begin
    if (RST) begin
      frm_q     <= RNE;
      fflags_q  <= '0;
      collide_q <= 1'b0;
    end else begin
      collide_q <= collide;
      if (csr_frm_wen_i) frm_q <= frm_t'(csr_frm_i);
      if (csr_fflags_wen_i) fflags_q <= fflags_t'(csr_fflags_i | fpu_fl);
      else if (fpu_wen_i)   fflags_q <= fflags_t'(fflags_q | fpu_fl);
    end
  end

  assign frm_o        = frm_q;
  assign fflags_o     = fflags_q;
  assign wr_collide_o = collide_q;

endmodule

// File: tb/tb_f_register_file_mp.sv
// Self-checking bench: directed fcsr/scoreboard/bypass cases plus random traffic vs a behavioural model.
module tb_f_register_file_mp;

  localparam int FLEN = 64;
  localparam int NR   = 32;
  localparam int NRD  = 3;
  localparam int AW   = 5;

  logic                      CLK = 1'b0;
  logic                      RST;
  logic [NRD-1:0][AW-1:0]    rd_addr;
  logic [NRD-1:0][FLEN-1:0]  rd_data;
  logic [NRD-1:0]            rd_busy;
  logic                      iss_valid;
  logic [AW-1:0]             iss_rd;
  logic                      fpu_wen;
  logic [AW-1:0]             fpu_waddr;
  logic [FLEN-1:0]           fpu_wdata;
  logic                      fpu_sp;
  logic [4:0]                fpu_flags;
  logic                      ld_wen;
  logic [AW-1:0]             ld_waddr;
  logic [FLEN-1:0]           ld_wdata;
  logic                      ld_sp;
  logic                      csr_frm_wen;
  logic [2:0]                csr_frm;
  logic                      csr_fflags_wen;
  logic [4:0]                csr_fflags;
  logic [2:0]                frm;
  logic [4:0]                fflags;
  logic                      wr_collide;

  int checks = 0;
  int passes = 0;

  f_register_file_mp #(.FLEN(FLEN), .NUM_REGS(NR), .NUM_RD(NRD), .BYPASS(1)) dut (
    .CLK(CLK), .RST(RST),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_busy_o(rd_busy),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd),
    .fpu_wen_i(fpu_wen), .fpu_waddr_i(fpu_waddr), .fpu_wdata_i(fpu_wdata),
    .fpu_sp_i(fpu_sp), .fpu_flags_i(fpu_flags),
    .ld_wen_i(ld_wen), .ld_waddr_i(ld_waddr), .ld_wdata_i(ld_wdata), .ld_sp_i(ld_sp),
    .csr_frm_wen_i(csr_frm_wen), .csr_frm_i(csr_frm),
    .csr_fflags_wen_i(csr_fflags_wen), .csr_fflags_i(csr_fflags),
    .frm_o(frm), .fflags_o(fflags), .wr_collide_o(wr_collide)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_mem  [NR];
  bit          m_busy [NR];
  logic [2:0]  m_frm;
  logic [4:0]  m_ff;
  bit          m_col;
  bit          m_ok = 0;

  function automatic logic [63:0] box(input logic [63:0] d, input bit sp);
    logic [63:0] r;
    r = sp ? {32'hFFFF_FFFF, d[31:0]} : d;
    return r;
  endfunction

  function automatic bit writes(input logic [AW-1:0] a);
    return (fpu_wen && fpu_waddr == a) || (ld_wen && ld_waddr == a);
  endfunction

  function automatic logic [63:0] exp_data(input logic [AW-1:0] a);
    if (fpu_wen && fpu_waddr == a) return box(fpu_wdata, fpu_sp);
    if (ld_wen && ld_waddr == a)   return box(ld_wdata, ld_sp);
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a);
    if (writes(a)) return iss_valid && iss_rd == a;
    return m_busy[a];
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NR; r++) begin
        m_mem[r]  <= '0;
        m_busy[r] <= 1'b0;
      end
      m_frm <= '0;
      m_ff  <= '0;
      m_col <= 1'b0;
      m_ok  <= 1'b1;
    end else begin
      if (ld_wen && !(fpu_wen && fpu_waddr == ld_waddr)) m_mem[ld_waddr] <= box(ld_wdata, ld_sp);
      if (fpu_wen) m_mem[fpu_waddr] <= box(fpu_wdata, fpu_sp);
      if (fpu_wen) m_busy[fpu_waddr] <= 1'b0;
      if (ld_wen && !(iss_valid && iss_rd == ld_waddr)) m_busy[ld_waddr] <= 1'b0;
      if (iss_valid) m_busy[iss_rd] <= 1'b1;
      m_col <= fpu_wen && ld_wen && (fpu_waddr == ld_waddr);
      if (csr_frm_wen) m_frm <= csr_frm;
      if (csr_fflags_wen) m_ff <= csr_fflags | (fpu_wen ? fpu_flags : 5'b0);
      else if (fpu_wen)   m_ff <= m_ff | fpu_flags;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge CLK) begin
    if (m_ok) begin
      for (int p = 0; p < NRD; p++) begin
        chk($sformatf("rd_data[%0d]", p), rd_data[p], exp_data(rd_addr[p]));
        chk($sformatf("rd_busy[%0d]", p), {63'b0, rd_busy[p]}, {63'b0, exp_busy(rd_addr[p])});
      end
      chk("frm", {61'b0, frm}, {61'b0, m_frm});
      chk("fflags", {59'b0, fflags}, {59'b0, m_ff});
      chk("wr_collide", {63'b0, wr_collide}, {63'b0, m_col});
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    iss_valid = 0; iss_rd = '0;
    fpu_wen = 0; fpu_waddr = '0; fpu_wdata = '0; fpu_sp = 0; fpu_flags = '0;
    ld_wen = 0; ld_waddr = '0; ld_wdata = '0; ld_sp = 0;
    csr_frm_wen = 0; csr_frm = '0; csr_fflags_wen = 0; csr_fflags = '0;
  endtask

  task automatic next();
    @(posedge CLK); #1;
    idle();
  endtask

  function automatic logic [AW-1:0] raddr();
    return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NR-1));
  endfunction

  initial begin
    RST = 1'b1;
    rd_addr = '0;
    idle();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Reset read-back of every register on all ports
    for (int a = 0; a < 11; a++) begin
      for (int p = 0; p < NRD; p++) rd_addr[p] = AW'(a * 3 + p);
      #3;
      for (int p = 0; p < NRD; p++) begin
        chk("rst_data", rd_data[p], 64'h0);
        chk("rst_busy", {63'b0, rd_busy[p]}, 64'h0);
      end
      chk("rst_frm", {61'b0, frm}, 64'h0);
      chk("rst_fflags", {59'b0, fflags}, 64'h0);
      next();
    end

    // Write with same-cycle bypass, then stored value
    fpu_wen = 1; fpu_waddr = 5; fpu_wdata = 64'h3F80_0000; rd_addr[0] = 5;
    #3 chk("bypass_f5", rd_data[0], 64'h3F80_0000);
    next();
    #3 chk("stored_f5", rd_data[0], 64'h3F80_0000);
    next();

    // Write collision
    fpu_wen = 1; fpu_waddr = 3; fpu_wdata = 64'h1111_1111;
    ld_wen = 1; ld_waddr = 3; ld_wdata = 64'h2222_2222; rd_addr[0] = 3;
    #3 chk("coll_bypass", rd_data[0], 64'h1111_1111);
    chk("coll_pre", {63'b0, wr_collide}, 64'h0);
    next();
    #3 chk("coll_f3", rd_data[0], 64'h1111_1111);
    chk("coll_pulse", {63'b0, wr_collide}, 64'h1);
    next();
    #3 chk("coll_clear", {63'b0, wr_collide}, 64'h0);
    next();

    // NaN-boxed single-precision load
    ld_wen = 1; ld_waddr = 7; ld_sp = 1; ld_wdata = 64'h0000_0000_4049_0FDB;
    next();
    rd_addr[0] = 7;
    #3 chk("nanbox_f7", rd_data[0], 64'hFFFF_FFFF_4049_0FDB);
    next();

    // Scoreboard
    rd_addr[1] = 9; iss_valid = 1; iss_rd = 9;
    #3 chk("sb_pre", {63'b0, rd_busy[1]}, 64'h0);
    next();
    #3 chk("sb_issued", {63'b0, rd_busy[1]}, 64'h1);
    iss_valid = 1; iss_rd = 9; fpu_wen = 1; fpu_waddr = 9; fpu_wdata = 64'h1;
    #1 chk("sb_set_wins_byp", {63'b0, rd_busy[1]}, 64'h1);
    next();
    #3 chk("sb_set_wins", {63'b0, rd_busy[1]}, 64'h1);
    fpu_wen = 1; fpu_waddr = 9; fpu_wdata = 64'h2;
    #1 chk("sb_done_byp", {63'b0, rd_busy[1]}, 64'h0);
    next();
    #3 chk("sb_done", {63'b0, rd_busy[1]}, 64'h0);

    // fcsr
    fpu_wen = 1; fpu_waddr = 1; fpu_flags = 5'b00001;
    next();
    fpu_wen = 1; fpu_waddr = 1; fpu_flags = 5'b10000;
    next();
    #3 chk("fflags_or", {59'b0, fflags}, 64'h11);
    csr_fflags_wen = 1; csr_fflags = 5'b00000; fpu_wen = 1; fpu_waddr = 2; fpu_flags = 5'b00100;
    next();
    #3 chk("fflags_csr", {59'b0, fflags}, 64'h04);
    csr_frm_wen = 1; csr_frm = 3'b001;
    next();
    #3 chk("frm_write", {61'b0, frm}, 64'h1);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      next();
      RST = ($urandom_range(0, 149) == 0);
      for (int p = 0; p < NRD; p++) rd_addr[p] = raddr();
      iss_valid = ($urandom_range(0, 2) == 0); iss_rd = raddr();
      fpu_wen = ($urandom_range(0, 1) == 0); fpu_waddr = raddr();
      fpu_wdata = {$urandom, $urandom}; fpu_sp = $urandom_range(0, 1) == 1;
      fpu_flags = 5'($urandom);
      ld_wen = ($urandom_range(0, 1) == 0); ld_waddr = raddr();
      ld_wdata = {$urandom, $urandom}; ld_sp = $urandom_range(0, 1) == 1;
      csr_frm_wen = ($urandom_range(0, 7) == 0); csr_frm = 3'($urandom);
      csr_fflags_wen = ($urandom_range(0, 7) == 0); csr_fflags = 5'($urandom);
    end
    next();
    RST = 1'b0;
    repeat (3) next();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
